// File: rtl/tlb_pkg.sv
// Shared TLB definitions: default geometry and the per-entry record.
// The entry struct is sized for the default geometry (VPN/PPN of
// TLB_VA_WIDTH/TLB_PA_WIDTH minus TLB_OFFSET bits).
package tlb_pkg;
   localparam int TLB_VA_WIDTH = 32;
   localparam int TLB_PA_WIDTH = 32;
   localparam int TLB_OFFSET   = 12;
   localparam int TLB_ENTRIES  = 8;
   localparam int TLB_VPN_W    = TLB_VA_WIDTH - TLB_OFFSET;
   localparam int TLB_PPN_W    = TLB_PA_WIDTH - TLB_OFFSET;

   typedef struct packed {
      logic                 valid;
      logic [TLB_VPN_W-1:0] vpn;
      logic [TLB_PPN_W-1:0] ppn;
   } tlb_entry_t;
endpackage

// File: rtl/assoc_tlb_if.sv
// Lookup / response / fill / flush bus of the associative TLB.
// master: requester side (drives req, fill, flush; sees ready and resp)
// slave : TLB side
interface assoc_tlb_if #(
   parameter int VA_WIDTH = 32,
   parameter int PA_WIDTH = 32,
   parameter int OFFSET   = 12
);
   localparam int VPN_W = VA_WIDTH - OFFSET;
   localparam int PPN_W = PA_WIDTH - OFFSET;

   logic                req_valid_i;
   logic                req_ready_o;
   logic [VA_WIDTH-1:0] req_vaddr_i;
   logic                req_priv_i;
   logic                resp_valid_o;
   logic [PA_WIDTH-1:0] resp_paddr_o;
   logic                resp_miss_o;
   logic                fill_valid_i;
   logic [VPN_W-1:0]    fill_vpn_i;
   logic [PPN_W-1:0]    fill_ppn_i;
   logic                flush_i;

   modport master (
      output req_valid_i, req_vaddr_i, req_priv_i,
      output fill_valid_i, fill_vpn_i, fill_ppn_i, flush_i,
      input  req_ready_o, resp_valid_o, resp_paddr_o, resp_miss_o
   );

   modport slave (
      input  req_valid_i, req_vaddr_i, req_priv_i,
      input  fill_valid_i, fill_vpn_i, fill_ppn_i, flush_i,
      output req_ready_o, resp_valid_o, resp_paddr_o, resp_miss_o
   );
endinterface

// File: rtl/tlb_entry_match.sv
// Single-entry VPN comparator, gated by the entry's valid bit.
// Ports: valid/entry_vpn (stored entry), lookup_vpn (probe), match (1-bit).
module tlb_entry_match #(
   parameter int VPN_W = 20
) (
   input  logic             valid,
   input  logic [VPN_W-1:0] entry_vpn,
   input  logic [VPN_W-1:0] lookup_vpn,
   output logic             match
);
   assign match = valid && (entry_vpn == lookup_vpn);
endmodule

// File: rtl/assoc_tlb.sv
// Fully associative TLB with one-cycle registered lookup, fill with
// dedup / free-slot / round-robin victim choice, flush and hit/miss counters.
// Ports: clk, reset (sync, active high); bus (slave side of assoc_tlb_if);
//        hit_count_o / miss_count_o (32-bit wrapping statistics).
module assoc_tlb
   import tlb_pkg::*;
#(
   parameter int VA_WIDTH = TLB_VA_WIDTH,
   parameter int PA_WIDTH = TLB_PA_WIDTH,
   parameter int OFFSET   = TLB_OFFSET,
   parameter int ENTRIES  = TLB_ENTRIES
) (
   input  logic        clk,
   input  logic        reset,
   assoc_tlb_if.slave  bus,
   output logic [31:0] hit_count_o,
   output logic [31:0] miss_count_o
);
   localparam int VPN_W = VA_WIDTH - OFFSET;
   localparam int IDX_W = $clog2(ENTRIES);

   tlb_entry_t [ENTRIES-1:0] entries;
   logic [IDX_W-1:0]         rr_ptr;
   logic [ENTRIES-1:0]       match;
   logic [IDX_W-1:0]         hit_idx, dup_idx, free_idx, victim;
   logic                     hit, dup_hit, free_hit, accept;
   logic [VPN_W-1:0]         lookup_vpn;
   logic                     resp_valid, resp_miss;
   logic [PA_WIDTH-1:0]      resp_paddr;

   assign lookup_vpn       = bus.req_vaddr_i[VA_WIDTH-1:OFFSET];
   assign bus.req_ready_o  = !reset && !bus.flush_i;
   assign accept           = bus.req_valid_i && bus.req_ready_o;
   assign bus.resp_valid_o = resp_valid;
   assign bus.resp_miss_o  = resp_miss;
   assign bus.resp_paddr_o = resp_paddr;

   for (genvar g = 0; g < ENTRIES; g++) begin : g_match
      tlb_entry_match #(.VPN_W(VPN_W)) u_match (
         .valid      (entries[g].valid),
         .entry_vpn  (entries[g].vpn),
         .lookup_vpn (lookup_vpn),
         .match      (match[g])
      );
   end

   // Matches are one-hot (a VPN lives in at most one entry), so OR-ing
   // the indices of set bits is a plain one-hot-to-binary encode.
   always_comb begin
      hit_idx = '0;
      for (int i = 0; i < ENTRIES; i++)
         if (match[i]) hit_idx = hit_idx | IDX_W'(i);
   end
   assign hit = |match;

   // Fill victim: existing copy of the VPN, else lowest free, else rr_ptr.
   always_comb begin
      dup_hit  = 1'b0;
      dup_idx  = '0;
      free_hit = 1'b0;
      free_idx = '0;
      for (int i = ENTRIES - 1; i >= 0; i--) begin
         if (entries[i].valid && entries[i].vpn == bus.fill_vpn_i) begin
            dup_hit = 1'b1;
            dup_idx = IDX_W'(i);
         end
         if (!entries[i].valid) begin
            free_hit = 1'b1;
            free_idx = IDX_W'(i);
         end
      end
      victim = dup_hit ? dup_idx : (free_hit ? free_idx : rr_ptr);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < ENTRIES; i++) entries[i].valid <= 1'b0;
         rr_ptr       <= '0;
         hit_count_o  <= '0;
         miss_count_o <= '0;
         resp_valid   <= 1'b0;
         resp_miss    <= 1'b0;
         resp_paddr   <= '0;
      end else begin
         resp_valid <= accept;
         // Lookup reads pre-edge contents, so a same-cycle fill is unseen.
         if (accept) begin
            if (hit) begin
               resp_paddr  <= {entries[hit_idx].ppn, bus.req_vaddr_i[OFFSET-1:0]};
               resp_miss   <= 1'b0;
               hit_count_o <= hit_count_o + 32'd1;
            end else begin
               resp_paddr   <= bus.req_priv_i ? PA_WIDTH'(bus.req_vaddr_i) : '0;
               resp_miss    <= !bus.req_priv_i;
               miss_count_o <= miss_count_o + 32'd1;
            end
         end
         if (bus.flush_i) begin
            for (int i = 0; i < ENTRIES; i++) entries[i].valid <= 1'b0;
            rr_ptr <= '0;
         end else if (bus.fill_valid_i) begin
            entries[victim].valid <= 1'b1;
            entries[victim].vpn   <= bus.fill_vpn_i;
            entries[victim].ppn   <= bus.fill_ppn_i;
            if (!dup_hit && !free_hit) rr_ptr <= rr_ptr + 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_assoc_tlb.sv
// Directed bench for assoc_tlb: lookups, fills, replacement, flush, reset.
module tb_assoc_tlb;
   logic clk = 1'b0;
   logic reset;
   logic [31:0] hit_count, miss_count;
   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   assoc_tlb_if #(.VA_WIDTH(32), .PA_WIDTH(32), .OFFSET(12)) bus ();

   assoc_tlb #(.VA_WIDTH(32), .PA_WIDTH(32), .OFFSET(12), .ENTRIES(8)) dut (
      .clk          (clk),
      .reset        (reset),
      .bus          (bus),
      .hit_count_o  (hit_count),
      .miss_count_o (miss_count)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      bus.req_valid_i  = 1'b0;
      bus.req_vaddr_i  = '0;
      bus.req_priv_i   = 1'b0;
      bus.fill_valid_i = 1'b0;
      bus.fill_vpn_i   = '0;
      bus.fill_ppn_i   = '0;
      bus.flush_i      = 1'b0;
   endtask

   task automatic fill(input logic [19:0] vpn, input logic [19:0] ppn);
      @(negedge clk);
      bus.fill_valid_i = 1'b1;
      bus.fill_vpn_i   = vpn;
      bus.fill_ppn_i   = ppn;
      @(posedge clk);
      #1 idle();
   endtask

   // One lookup: checks ready, then the response one cycle later, then
   // that the response pulse drops the following cycle.
   task automatic lookup(input string tag, input logic [31:0] va, input logic priv,
                         input logic [31:0] exp_pa, input logic exp_miss);
      @(negedge clk);
      bus.req_valid_i = 1'b1;
      bus.req_vaddr_i = va;
      bus.req_priv_i  = priv;
      #1 chk({tag, "_ready"}, 32'(bus.req_ready_o), 32'd1);
      @(posedge clk);
      #1 idle();
      chk({tag, "_rvalid"}, 32'(bus.resp_valid_o), 32'd1);
      chk({tag, "_paddr"}, bus.resp_paddr_o, exp_pa);
      chk({tag, "_miss"}, 32'(bus.resp_miss_o), 32'(exp_miss));
      @(posedge clk);
      #1 chk({tag, "_pulse"}, 32'(bus.resp_valid_o), 32'd0);
   endtask

   initial begin
      idle();
      reset = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #1 chk("rst_ready", 32'(bus.req_ready_o), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("rst_rvalid", 32'(bus.resp_valid_o), 32'd0);
      chk("rst_paddr", bus.resp_paddr_o, 32'd0);
      chk("rst_miss", 32'(bus.resp_miss_o), 32'd0);
      chk("rst_hits", hit_count, 32'd0);
      chk("rst_misses", miss_count, 32'd0);

      // Unprivileged miss on empty TLB
      lookup("miss0", 32'h0000_5123, 1'b0, 32'h0, 1'b1);
      chk("miss0_cnt", miss_count, 32'd1);

      // Fill then hit
      fill(20'h00005, 20'h000A0);
      lookup("hit0", 32'h0000_5123, 1'b0, 32'h000A_0123, 1'b0);
      chk("hit0_cnt", hit_count, 32'd1);

      // Overwrite same VPN
      fill(20'h00005, 20'h000B0);
      lookup("hit1", 32'h0000_5123, 1'b0, 32'h000B_0123, 1'b0);
      chk("hit1_cnt", hit_count, 32'd2);

      // Flush with simultaneous fill and lookup
      @(negedge clk);
      bus.flush_i      = 1'b1;
      bus.fill_valid_i = 1'b1;
      bus.fill_vpn_i   = 20'h00003;
      bus.fill_ppn_i   = 20'h00033;
      bus.req_valid_i  = 1'b1;
      bus.req_vaddr_i  = 32'h0000_3000;
      #1 chk("flush_ready", 32'(bus.req_ready_o), 32'd0);
      @(posedge clk);
      #1 idle();
      chk("flush_rvalid", 32'(bus.resp_valid_o), 32'd0);
      chk("flush_hits", hit_count, 32'd2);
      chk("flush_misses", miss_count, 32'd1);
      lookup("flush_vpn3", 32'h0000_3000, 1'b0, 32'h0, 1'b1);
      lookup("flush_vpn5", 32'h0000_5123, 1'b0, 32'h0, 1'b1);
      chk("flush_misses2", miss_count, 32'd3);

      // Privileged identity on empty TLB
      lookup("priv", 32'h1234_5678, 1'b1, 32'h1234_5678, 1'b0);
      chk("priv_cnt", miss_count, 32'd4);

      // Fill all 8 entries, then round-robin replacement
      for (int i = 1; i <= 8; i++) fill(20'(i), 20'(32'h100 + i));
      fill(20'h00009, 20'h00109);
      lookup("rr_vpn1", 32'h0000_1ABC, 1'b0, 32'h0, 1'b1);
      lookup("rr_vpn9", 32'h0000_9ABC, 1'b0, 32'h0010_9ABC, 1'b0);
      lookup("rr_vpn2", 32'h0000_2ABC, 1'b0, 32'h0010_2ABC, 1'b0);
      chk("rr_hits", hit_count, 32'd4);
      chk("rr_misses", miss_count, 32'd5);
      fill(20'h0000A, 20'h0010A);
      lookup("rr2_vpn2", 32'h0000_2ABC, 1'b0, 32'h0, 1'b1);
      lookup("rr2_vpnA", 32'h0000_AABC, 1'b0, 32'h0010_AABC, 1'b0);
      lookup("rr2_vpn3", 32'h0000_3ABC, 1'b0, 32'h0010_3ABC, 1'b0);

      // Same-cycle fill and lookup: lookup sees pre-fill contents
      @(negedge clk);
      bus.fill_valid_i = 1'b1;
      bus.fill_vpn_i   = 20'h0000B;
      bus.fill_ppn_i   = 20'h0010B;
      bus.req_valid_i  = 1'b1;
      bus.req_vaddr_i  = 32'h0000_BABC;
      @(posedge clk);
      #1 idle();
      chk("rbw_rvalid", 32'(bus.resp_valid_o), 32'd1);
      chk("rbw_miss", 32'(bus.resp_miss_o), 32'd1);
      lookup("rbw_after", 32'h0000_BABC, 1'b0, 32'h0010_BABC, 1'b0);
      lookup("rbw_vpn3", 32'h0000_3ABC, 1'b0, 32'h0, 1'b1);
      chk("rbw_hits", hit_count, 32'd7);
      chk("rbw_misses", miss_count, 32'd8);

      // Reset with a request in flight
      @(negedge clk);
      reset = 1'b1;
      bus.req_valid_i = 1'b1;
      bus.req_vaddr_i = 32'h0000_BABC;
      #1 chk("rst2_ready", 32'(bus.req_ready_o), 32'd0);
      @(posedge clk);
      #1 idle();
      chk("rst2_rvalid", 32'(bus.resp_valid_o), 32'd0);
      chk("rst2_hits", hit_count, 32'd0);
      chk("rst2_misses", miss_count, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      lookup("rst2_vpnB", 32'h0000_BABC, 1'b0, 32'h0, 1'b1);
      chk("rst2_misses2", miss_count, 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/assoc_tlb.md
ASSOC_TLB -- requirements
Module: assoc_tlb

Interface
REQ-001 Parameter VA_WIDTH, default 32: virtual address width in bits.
REQ-002 Parameter PA_WIDTH, default 32: physical address width in bits.
REQ-003 Parameter OFFSET, default 12: page-offset width in bits; VPN = VA_WIDTH-OFFSET bits, PPN = PA_WIDTH-OFFSET bits.
REQ-004 Parameter ENTRIES, default 8: entry count, power of two, at least 2.
REQ-005 Port clk, input, 1: single clock; all state changes on rising edge.
REQ-006 Port reset, input, 1: synchronous, active-high reset.
REQ-007 Port req_valid_i, input, 1: lookup request.
REQ-008 Port req_ready_o, output, 1: lookup accepted when high together with req_valid_i.
REQ-009 Port req_vaddr_i, input, VA_WIDTH: lookup virtual address.
REQ-010 Port req_priv_i, input, 1: privileged lookup; identity-map on miss.
REQ-011 Port resp_valid_o, output, 1: response valid, one-cycle pulse.
REQ-012 Port resp_paddr_o, output, PA_WIDTH: translated address.
REQ-013 Port resp_miss_o, output, 1: unprivileged lookup missed.
REQ-014 Port fill_valid_i, input, 1: write a VPN->PPN mapping.
REQ-015 Port fill_vpn_i / fill_ppn_i, input, VPN / PPN widths: mapping to write.
REQ-016 Port flush_i, input, 1: invalidate all entries.
REQ-017 Port hit_count_o / miss_count_o, output, 32 each: statistics counters.

Function
REQ-018 Storage: per entry valid bit, VPN, PPN; fully associative match on VPN, valid entries only.
REQ-019 Lookup latency: request accepted in cycle N, resp_valid_o high in cycle N+1 only, registered outputs.
REQ-020 req_ready_o = !reset and !flush_i; a request with flush_i high is not accepted and produces no response.
REQ-021 Hit: resp_paddr_o = {matched PPN, vaddr[OFFSET-1:0]}, resp_miss_o = 0; hit_count_o increments.
REQ-022 Miss with req_priv_i = 1: resp_paddr_o = vaddr zero-extended or truncated to PA_WIDTH, resp_miss_o = 0; miss_count_o increments.
REQ-023 Miss with req_priv_i = 0: resp_paddr_o = 0, resp_miss_o = 1; miss_count_o increments.
REQ-024 Counters wrap from 0xFFFFFFFF to 0; a privileged identity access counts as a miss.
REQ-025 Fill victim select, in priority order: entry already holding fill_vpn_i (PPN overwritten, no duplicate); else lowest-index invalid entry; else entry at round-robin pointer rr_ptr.
REQ-026 rr_ptr advances by one, mod ENTRIES, only when a fill uses it.
REQ-027 Fill takes effect at the clock edge; a lookup accepted in the same cycle sees pre-fill contents (read-before-write).
REQ-028 flush_i clears all valid bits and rr_ptr at the edge; counters are preserved; simultaneous fill_valid_i is dropped.
REQ-029 At most one entry matches any VPN at any time.

Reset
REQ-030 Reset clears all valid bits, rr_ptr, both counters, resp_valid_o, resp_miss_o and resp_paddr_o to 0.
REQ-031 Reset drives req_ready_o low in the same cycle; a request in flight is discarded with no response.
REQ-032 VPN/PPN storage needs no reset value.

Structure
REQ-033 Shared package tlb_pkg holds default OFFSET, PA_WIDTH and ENTRIES constants and the entry struct typedef (valid, vpn, ppn).
REQ-034 One sub-module, tlb_entry_match: a single entry's VPN compare gated by valid, giving a one-bit match; instantiated ENTRIES times.
REQ-035 Hit index comes from a one-hot-to-binary encoder in assoc_tlb; no priority chain is needed because of REQ-029.

Verification
REQ-036 Reset, then unprivileged lookup of 0x0000_5123 -> next cycle resp_miss_o=1, resp_paddr_o=0, miss_count_o=1.
REQ-037 Fill VPN 0x00005 -> PPN 0x000A0, then lookup 0x0000_5123 -> resp_paddr_o=0x000A_0123, resp_miss_o=0, hit_count_o=1.
REQ-038 Fill VPN 0x00005 -> PPN 0x000B0 again -> one valid entry only; lookup returns 0x000B_0123.
REQ-039 ENTRIES=8: fill VPNs 1..8, then VPN 9 -> entry 0 replaced; lookup VPN 1 misses, VPN 9 and VPN 2 hit; next fill replaces entry 1.
REQ-040 Privileged lookup of 0x1234_5678 on empty TLB -> resp_paddr_o=0x1234_5678, resp_miss_o=0, miss_count_o increments.
REQ-041 flush_i together with fill VPN 3 and a lookup request -> req_ready_o=0, no response; all entries invalid; VPN 3 not present; counters unchanged.
